// File: rtl/linkspeed_tx.sv
// linkspeed_tx: transmit-side sequencer for the MBTRAIN LINKSPEED substate.
//
// The block asks the remote partner to start a point test, runs the local
// point test, reports the outcome (done / error / phyretrain) and, after an
// error, requests an exit to REPAIR or SPEED_DEGRADE depending on which half
// of the 16 lanes survived.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_en                       substate enable; 0 aborts to IDLE
//   i_sideband_message [3:0]   decoded response from the partner
//   i_rx_valid                 sideband slot busy with the RX-side block
//   i_busy_negedge_detected    sideband finished sending our message
//   i_point_test_ack           point test finished
//   i_lanes_result [15:0]      per-lane pass flags (1 = pass)
//   i_valid_framing_error      framing error on the valid lane
//   i_comming_from_repair      this entry follows REPAIR
//   i_phyretrain_req           local request to exit to PHYRETRAIN
//   o_sideband_message [3:0]   request to transmit
//   o_valid_tx                 o_sideband_message valid to sideband
//   o_point_test_en            starts the TX-initiated point test
//   o_test_ack                 TX side complete
//   o_exit_status [1:0]        00 done, 01 repair, 10 degrade, 11 phyretrain
//
// Send handshake: in a SEND_* state o_valid_tx is raised on the first cycle
// the sideband slot is free (i_rx_valid=0) and dropped on
// i_busy_negedge_detected. The falling edge of o_valid_tx (seen through a
// one-cycle delayed copy) is the send-complete event that advances the FSM.
module linkspeed_tx (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic [3:0]  i_sideband_message,
    input  logic        i_rx_valid,
    input  logic        i_busy_negedge_detected,
    input  logic        i_point_test_ack,
    input  logic [15:0] i_lanes_result,
    input  logic        i_valid_framing_error,
    input  logic        i_comming_from_repair,
    input  logic        i_phyretrain_req,
    output logic [3:0]  o_sideband_message,
    output logic        o_valid_tx,
    output logic        o_point_test_en,
    output logic        o_test_ack,
    output logic [1:0]  o_exit_status
);

    localparam logic [3:0] START_REQ      = 4'b0001;
    localparam logic [3:0] START_RESP     = 4'b0010;
    localparam logic [3:0] ERROR_REQ      = 4'b0011;
    localparam logic [3:0] ERROR_RESP     = 4'b0100;
    localparam logic [3:0] REPAIR_REQ     = 4'b0101;
    localparam logic [3:0] REPAIR_RESP    = 4'b0110;
    localparam logic [3:0] DEGRADE_REQ    = 4'b0111;
    localparam logic [3:0] DEGRADE_RESP   = 4'b1000;
    localparam logic [3:0] DONE_REQ       = 4'b1001;
    localparam logic [3:0] DONE_RESP      = 4'b1010;
    localparam logic [3:0] PHYRETRAIN_REQ = 4'b1011;
    localparam logic [3:0] PHYRETRAIN_RESP= 4'b1100;

    typedef enum logic [3:0] {
        IDLE,
        SEND_START_REQ,
        WAIT_START_RESP,
        POINT_TEST,
        SEND_RESULT_REQ,
        WAIT_RESULT_RESP,
        SEND_EXIT_REQ,
        WAIT_EXIT_RESP,
        TEST_FINISH
    } state_t;

    state_t      state, next_state;
    logic        pending;
    logic        valid_q;
    logic [15:0] lanes_q;

    logic        send_complete;
    logic        in_send;
    logic        start_match, done_match, phy_match, err_match;
    logic        repair_match, degrade_match;
    logic        half_pass_now, half_pass_latched;
    logic [3:0]  result_msg;
    logic [3:0]  exit_msg;

    assign send_complete = valid_q && !o_valid_tx;
    assign in_send = (state == SEND_START_REQ) || (state == SEND_RESULT_REQ) ||
                     (state == SEND_EXIT_REQ);

    // A response only counts when it answers the request currently held.
    assign start_match   = (i_sideband_message == START_RESP);
    assign done_match    = (o_sideband_message == DONE_REQ)       && (i_sideband_message == DONE_RESP);
    assign phy_match     = (o_sideband_message == PHYRETRAIN_REQ) && (i_sideband_message == PHYRETRAIN_RESP);
    assign err_match     = (o_sideband_message == ERROR_REQ)      && (i_sideband_message == ERROR_RESP);
    assign repair_match  = (o_sideband_message == REPAIR_REQ)     && (i_sideband_message == REPAIR_RESP);
    assign degrade_match = (o_sideband_message == DEGRADE_REQ)    && (i_sideband_message == DEGRADE_RESP);

    assign half_pass_now     = (&i_lanes_result[7:0]) || (&i_lanes_result[15:8]);
    assign half_pass_latched = (&lanes_q[7:0]) || (&lanes_q[15:8]);

    always_comb begin
        result_msg = ERROR_REQ;
        if (i_phyretrain_req)
            result_msg = PHYRETRAIN_REQ;
        else if ((&i_lanes_result) && !i_valid_framing_error)
            result_msg = DONE_REQ;
        else if (i_comming_from_repair && half_pass_now && !i_valid_framing_error)
            result_msg = DONE_REQ;
    end

    assign exit_msg = half_pass_latched ? REPAIR_REQ : DEGRADE_REQ;

    always_comb begin
        next_state = state;
        if (!i_en) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:             next_state = SEND_START_REQ;
                SEND_START_REQ:   if (send_complete) next_state = WAIT_START_RESP;
                WAIT_START_RESP:  if (start_match) next_state = POINT_TEST;
                POINT_TEST:       if (i_point_test_ack) next_state = SEND_RESULT_REQ;
                SEND_RESULT_REQ:  if (send_complete) next_state = WAIT_RESULT_RESP;
                WAIT_RESULT_RESP: begin
                    if (done_match || phy_match) next_state = TEST_FINISH;
                    else if (err_match)          next_state = SEND_EXIT_REQ;
                end
                SEND_EXIT_REQ:    if (send_complete) next_state = WAIT_EXIT_RESP;
                WAIT_EXIT_RESP:   if (repair_match || degrade_match) next_state = TEST_FINISH;
                TEST_FINISH:      next_state = TEST_FINISH;
                default:          next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_sideband_message <= 4'b0000;
            o_valid_tx         <= 1'b0;
            o_point_test_en    <= 1'b0;
            o_test_ack         <= 1'b0;
            o_exit_status      <= 2'b00;
            pending            <= 1'b0;
            valid_q            <= 1'b0;
            lanes_q            <= 16'h0000;
        end else if (!i_en) begin
            o_sideband_message <= 4'b0000;
            o_valid_tx         <= 1'b0;
            o_point_test_en    <= 1'b0;
            o_test_ack         <= 1'b0;
            o_exit_status      <= 2'b00;
            pending            <= 1'b0;
            valid_q            <= 1'b0;
        end else begin
            valid_q <= o_valid_tx;
            case (state)
                IDLE: o_sideband_message <= START_REQ;
                SEND_START_REQ, SEND_RESULT_REQ, SEND_EXIT_REQ: begin
                    // send_complete blocks a second raise in the cycle
                    // before the FSM leaves the SEND state.
                    if (i_busy_negedge_detected)
                        o_valid_tx <= 1'b0;
                    else if (in_send && !o_valid_tx && !send_complete && !i_rx_valid)
                        o_valid_tx <= 1'b1;
                    if (o_valid_tx)
                        pending <= 1'b0;
                    else if (i_rx_valid && !send_complete)
                        pending <= 1'b1;
                end
                WAIT_START_RESP: if (start_match) o_point_test_en <= 1'b1;
                POINT_TEST: begin
                    if (i_point_test_ack) begin
                        o_point_test_en    <= 1'b0;
                        o_sideband_message <= result_msg;
                        lanes_q            <= i_lanes_result;
                    end
                end
                WAIT_RESULT_RESP: begin
                    if (done_match || phy_match) begin
                        o_sideband_message <= 4'b0000;
                        o_test_ack         <= 1'b1;
                        o_exit_status      <= phy_match ? 2'b11 : 2'b00;
                    end else if (err_match) begin
                        o_sideband_message <= exit_msg;
                    end
                end
                WAIT_EXIT_RESP: begin
                    if (repair_match || degrade_match) begin
                        o_sideband_message <= 4'b0000;
                        o_test_ack         <= 1'b1;
                        o_exit_status      <= repair_match ? 2'b01 : 2'b10;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_linkspeed_tx.sv
// tb_linkspeed_tx: self-checking bench for linkspeed_tx. The partner side is
// emulated by tasks; expected requests and exit status come from a small
// rule-based model and are queued in exp_q.
module tb_linkspeed_tx;

    localparam logic [3:0] START_REQ      = 4'b0001;
    localparam logic [3:0] ERROR_REQ      = 4'b0011;
    localparam logic [3:0] ERROR_RESP     = 4'b0100;
    localparam logic [3:0] REPAIR_REQ     = 4'b0101;
    localparam logic [3:0] REPAIR_RESP    = 4'b0110;
    localparam logic [3:0] DEGRADE_REQ    = 4'b0111;
    localparam logic [3:0] DEGRADE_RESP   = 4'b1000;
    localparam logic [3:0] DONE_REQ       = 4'b1001;
    localparam logic [3:0] DONE_RESP      = 4'b1010;
    localparam logic [3:0] PHYRETRAIN_REQ = 4'b1011;

    // clock / reset
    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        i_en;
    logic [3:0]  i_sideband_message;
    logic        i_rx_valid;
    logic        i_busy_negedge_detected;
    logic        i_point_test_ack;
    logic [15:0] i_lanes_result;
    logic        i_valid_framing_error;
    logic        i_comming_from_repair;
    logic        i_phyretrain_req;
    logic [3:0]  o_sideband_message;
    logic        o_valid_tx;
    logic        o_point_test_en;
    logic        o_test_ack;
    logic [1:0]  o_exit_status;

    linkspeed_tx dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .i_en                    (i_en),
        .i_sideband_message      (i_sideband_message),
        .i_rx_valid              (i_rx_valid),
        .i_busy_negedge_detected (i_busy_negedge_detected),
        .i_point_test_ack        (i_point_test_ack),
        .i_lanes_result          (i_lanes_result),
        .i_valid_framing_error   (i_valid_framing_error),
        .i_comming_from_repair   (i_comming_from_repair),
        .i_phyretrain_req        (i_phyretrain_req),
        .o_sideband_message      (o_sideband_message),
        .o_valid_tx              (o_valid_tx),
        .o_point_test_en         (o_point_test_en),
        .o_test_ack              (o_test_ack),
        .o_exit_status           (o_exit_status)
    );

    int          tests = 0;
    int          fails = 0;
    logic [3:0]  exp_q[$];

    // reference model
    function automatic logic [3:0] model_result(input logic [15:0] lanes, input bit repair,
                                                input bit phy, input bit frame);
        bit half_ok;
        half_ok = (lanes[7:0] == 8'hFF) || (lanes[15:8] == 8'hFF);
        if (phy) return PHYRETRAIN_REQ;
        if (lanes == 16'hFFFF && !frame) return DONE_REQ;
        if (repair && half_ok && !frame) return DONE_REQ;
        return ERROR_REQ;
    endfunction

    function automatic logic [3:0] model_exit(input logic [15:0] lanes);
        if ((lanes[7:0] == 8'hFF) || (lanes[15:8] == 8'hFF)) return REPAIR_REQ;
        return DEGRADE_REQ;
    endfunction

    function automatic logic [1:0] model_status(input logic [3:0] last_req);
        case (last_req)
            REPAIR_REQ:     return 2'b01;
            DEGRADE_REQ:    return 2'b10;
            PHYRETRAIN_REQ: return 2'b11;
            default:        return 2'b00;
        endcase
    endfunction

    // Every response code is its request code plus one.
    function automatic logic [3:0] resp_of(input logic [3:0] req);
        return req + 4'd1;
    endfunction

    function automatic logic [3:0] stray_of(input logic [3:0] req);
        case (req)
            ERROR_REQ:   return DONE_RESP;
            REPAIR_REQ:  return DEGRADE_RESP;
            DEGRADE_REQ: return REPAIR_RESP;
            default:     return ERROR_RESP;
        endcase
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        i_en = 0; i_sideband_message = 0; i_rx_valid = 0; i_busy_negedge_detected = 0;
        i_point_test_ack = 0; i_lanes_result = 0; i_valid_framing_error = 0;
        i_comming_from_repair = 0; i_phyretrain_req = 0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 0;
        #1;
        tests++;
        if ({o_sideband_message, o_valid_tx, o_point_test_en, o_test_ack, o_exit_status} !== 9'd0) begin
            fails++;
            $display("FAIL reset_outputs got=%b want=0", {o_sideband_message, o_valid_tx,
                     o_point_test_en, o_test_ack, o_exit_status});
        end
        tick(); tick();
        rst_n = 1;
        tick();
    endtask

    // Full transaction with the partner emulated; comparisons inline.
    task automatic run_flow(input string name, input logic [15:0] lanes, input bit repair,
                            input bit phy, input bit frame, input bit stray);
        logic [3:0] res, e, last;
        bit ok;
        res = model_result(lanes, repair, phy, frame);
        exp_q.delete();
        exp_q.push_back(START_REQ);
        exp_q.push_back(res);
        if (res == ERROR_REQ) exp_q.push_back(model_exit(lanes));
        last = exp_q[exp_q.size()-1];
        i_comming_from_repair = repair;
        i_phyretrain_req = phy;
        i_valid_framing_error = frame;
        i_lanes_result = 16'($urandom);
        i_en = 1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ok = 0;
            for (int i = 0; i < 40; i++) begin
                if (o_valid_tx) begin ok = 1; break; end
                tick();
            end
            tests++;
            if (!ok) begin fails++; $display("FAIL %s valid_timeout req=%b", name, e); end
            tests++;
            if (o_sideband_message !== e) begin
                fails++; $display("FAIL %s request got=%b want=%b", name, o_sideband_message, e);
            end
            repeat ($urandom_range(0, 3)) tick();
            i_busy_negedge_detected = 1;
            tick();
            i_busy_negedge_detected = 0;
            tests++;
            if (o_valid_tx !== 1'b0) begin
                fails++; $display("FAIL %s valid_clear got=%b want=0", name, o_valid_tx);
            end
            if (stray) begin
                i_sideband_message = stray_of(e);
                repeat (4) tick();
                tests++;
                if ({o_test_ack, o_valid_tx, o_point_test_en} !== 3'b000) begin
                    fails++; $display("FAIL %s stray_ignored got=%b want=000", name,
                                      {o_test_ack, o_valid_tx, o_point_test_en});
                end
            end
            i_sideband_message = resp_of(e);
            ok = 0;
            for (int i = 0; i < 40; i++) begin
                if ((e == START_REQ) ? o_point_test_en : (o_test_ack || o_valid_tx)) begin
                    ok = 1; break;
                end
                tick();
            end
            i_sideband_message = 0;
            tests++;
            if (!ok) begin fails++; $display("FAIL %s resp_timeout req=%b", name, e); end
            if (e == START_REQ) begin
                i_lanes_result = lanes;
                repeat ($urandom_range(1, 4)) tick();
                i_point_test_ack = 1;
                tick();
                i_point_test_ack = 0;
                i_lanes_result = 16'($urandom);  // later values must not matter
                tests++;
                if (o_point_test_en !== 1'b0) begin
                    fails++; $display("FAIL %s point_en_clear got=%b want=0", name, o_point_test_en);
                end
            end
        end
        tick();
        tests++;
        if ({o_test_ack, o_exit_status, o_sideband_message} !== {1'b1, model_status(last), 4'b0000}) begin
            fails++; $display("FAIL %s finish got ack=%b st=%b msg=%b want ack=1 st=%b msg=0000",
                              name, o_test_ack, o_exit_status, o_sideband_message, model_status(last));
        end
        i_en = 0;
        tick();
        tests++;
        if ({o_sideband_message, o_valid_tx, o_point_test_en, o_test_ack, o_exit_status} !== 9'd0) begin
            fails++; $display("FAIL %s disable_clear got=%b want=0", name, {o_sideband_message,
                              o_valid_tx, o_point_test_en, o_test_ack, o_exit_status});
        end
        drive_idle();
        tick();
    endtask

    task automatic test_clean();       run_flow("clean",       16'hFFFF, 0, 0, 0, 0); endtask
    task automatic test_half_fail();   run_flow("half_fail",   16'h00FF, 0, 0, 0, 0); endtask
    task automatic test_total_fail();  run_flow("total_fail",  16'h0F0F, 0, 0, 0, 0); endtask
    task automatic test_post_repair(); run_flow("post_repair", 16'hFF00, 1, 0, 0, 1); endtask
    task automatic test_phyretrain();  run_flow("phyretrain",  16'hFFFF, 0, 1, 0, 1); endtask
    task automatic test_framing();     run_flow("framing",     16'hFFFF, 1, 0, 1, 0); endtask

    task automatic test_random();
        logic [15:0] l;
        for (int n = 0; n < 16; n++) begin
            case ($urandom_range(0, 3))
                0: l = 16'hFFFF;
                1: l = 16'h00FF | 16'($urandom_range(0, 255) << 8);
                2: l = 16'hFF00 | 16'($urandom_range(0, 255));
                default: l = 16'($urandom);
            endcase
            run_flow("random", l, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_contention();
        i_rx_valid = 1;
        i_en = 1;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (o_valid_tx !== 1'b0) begin
                fails++; $display("FAIL contention_hold cycle=%0d got=%b want=0", i, o_valid_tx);
            end
        end
        i_rx_valid = 0;
        tick();
        tests++;
        if ({o_valid_tx, o_sideband_message} !== {1'b1, START_REQ}) begin
            fails++; $display("FAIL contention_rise got=%b want=%b", {o_valid_tx, o_sideband_message},
                              {1'b1, START_REQ});
        end
        i_busy_negedge_detected = 1;
        tick();
        i_busy_negedge_detected = 0;
        tests++;
        if (o_valid_tx !== 1'b0) begin
            fails++; $display("FAIL contention_clear got=%b want=0", o_valid_tx);
        end
        tick();
        tests++;
        if (o_valid_tx !== 1'b0) begin
            fails++; $display("FAIL contention_no_reraise got=%b want=0", o_valid_tx);
        end
        drive_idle();
        tick();
    endtask

    task automatic test_abort();
        bit ok;
        i_en = 1;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (o_valid_tx) begin ok = 1; break; end
            tick();
        end
        i_busy_negedge_detected = 1;
        tick();
        i_busy_negedge_detected = 0;
        i_sideband_message = 4'b0010;
        for (int i = 0; i < 40; i++) begin
            if (o_point_test_en) break;
            tick();
        end
        i_sideband_message = 0;
        tests++;
        if (!(ok && o_point_test_en)) begin
            fails++; $display("FAIL abort_setup got valid_seen=%b pt_en=%b want 1 1", ok, o_point_test_en);
        end
        // disable and point-test ack in the same cycle: disable wins
        i_lanes_result = 16'hFFFF;
        i_point_test_ack = 1;
        i_en = 0;
        tick();
        i_point_test_ack = 0;
        tests++;
        if ({o_sideband_message, o_valid_tx, o_point_test_en, o_test_ack, o_exit_status} !== 9'd0) begin
            fails++; $display("FAIL abort_clear got=%b want=0", {o_sideband_message, o_valid_tx,
                              o_point_test_en, o_test_ack, o_exit_status});
        end
        tick();
        // asynchronous reset in the middle of a send
        i_en = 1;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (o_valid_tx) begin ok = 1; break; end
            tick();
        end
        tests++;
        if (!ok) begin fails++; $display("FAIL reset_mid_send_setup got=0 want=1"); end
        #2;
        rst_n = 0;
        #1;
        tests++;
        if ({o_valid_tx, o_sideband_message} !== 5'd0) begin
            fails++; $display("FAIL reset_mid_send got=%b want=0", {o_valid_tx, o_sideband_message});
        end
        drive_idle();
        tick();
        rst_n = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_clean();
        test_half_fail();
        test_total_fail();
        test_contention();
        test_post_repair();
        test_phyretrain();
        test_framing();
        test_random();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
